// File: rtl/ws2812_ctrl.sv
// WS2812 serial LED driver: fetches one GRB word per LED from an external select
// stage, serialises it MSB first with fixed-period bit cells, then issues the latch gap.
module ws2812_ctrl #(
  parameter int T_BIT   = 63,
  parameter int T0H     = 20,
  parameter int T1H     = 40,
  parameter int T_RST   = 15000,
  parameter int LED_NUM = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ws2812_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_start,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int BCW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int BW1 = BCW + 1;
  localparam int LCW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int RCW = $clog2(T_RST + 1);

  localparam logic [BCW-1:0] BIT_LAST = BCW'(T_BIT - 1);
  localparam logic [LCW-1:0] LED_LAST = LCW'(LED_NUM - 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(T_RST);
  localparam logic [RCW-1:0] RST_PRE  = RCW'(T_RST - 1);
  localparam logic [BW1-1:0] TH0      = BW1'(T0H);
  localparam logic [BW1-1:0] TH1      = BW1'(T1H);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_NEXT, S_RST} state_t;

  state_t         r_state;
  logic [23:0]    r_shift;
  logic [BCW-1:0] r_bit_cyc;
  logic [4:0]     r_bit_idx;
  logic [LCW-1:0] r_led_cnt;
  logic [RCW-1:0] r_rst_cnt;
  logic           r_pend;
  logic           r_dout;
  logic           r_cfg_start;
  logic           r_frame_done;

  logic [BW1-1:0] w_cyc_nxt;
  logic [BW1-1:0] w_th_cur;
  logic [BW1-1:0] w_th_nxt;
  logic [BW1-1:0] w_th_load;
  logic           w_bit_end;
  logic           w_last_bit;

  assign w_cyc_nxt  = {1'b0, r_bit_cyc} + BW1'(1);
  assign w_th_cur   = r_shift[23] ? TH1 : TH0;
  assign w_th_nxt   = r_shift[22] ? TH1 : TH0;
  assign w_th_load  = cfg_data[23] ? TH1 : TH0;
  assign w_bit_end  = (r_bit_cyc == BIT_LAST);
  assign w_last_bit = (r_bit_idx == 5'd23);

  // dout is computed one cycle ahead from the next (bit, bit_cyc) so the registered
  // line is high exactly while the live bit_cyc is below the bit's high threshold.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cyc    <= '0;
      r_bit_idx    <= '0;
      r_led_cnt    <= '0;
      r_rst_cnt    <= '0;
      r_pend       <= 1'b0;
      r_dout       <= 1'b0;
      r_cfg_start  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_dout       <= 1'b0;
      r_cfg_start  <= 1'b0;
      r_frame_done <= 1'b0;
      if (ws2812_start && (r_state != S_IDLE)) r_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (ws2812_start || r_pend) begin
            r_state <= S_LOAD;
            r_pend  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_shift   <= cfg_data;
          r_bit_idx <= '0;
          r_bit_cyc <= '0;
          r_dout    <= (w_th_load != '0);
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (w_bit_end) begin
            r_bit_cyc <= '0;
            r_shift   <= {r_shift[22:0], 1'b0};
            if (w_last_bit) begin
              r_bit_idx   <= '0;
              r_cfg_start <= 1'b1;
              r_state     <= S_NEXT;
            end else begin
              r_bit_idx <= r_bit_idx + 5'd1;
              r_dout    <= (w_th_nxt != '0);
            end
          end else begin
            r_bit_cyc <= r_bit_cyc + BCW'(1);
            r_dout    <= (w_cyc_nxt < w_th_cur);
          end
        end
        S_NEXT: begin
          if (r_led_cnt == LED_LAST) begin
            r_led_cnt <= '0;
            r_rst_cnt <= '0;
            r_state   <= S_RST;
          end else begin
            r_led_cnt <= r_led_cnt + LCW'(1);
            r_state   <= S_LOAD;
          end
        end
        S_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            r_rst_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_rst_cnt <= r_rst_cnt + RCW'(1);
            if (r_rst_cnt == RST_PRE) r_frame_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign cfg_start  = r_cfg_start;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Directed bench for ws2812_ctrl: a model select stage feeds indexed GRB words and a
// decoder rebuilds each word from dout, checked against a queue of expected words.
module tb_ws2812_ctrl;

  localparam int T_BIT = 12;
  localparam int T0H   = 4;
  localparam int T1H   = 8;
  localparam int T_RST = 40;
  localparam int N     = 12;
  localparam int FRAME = N * (24 * T_BIT + 2) + T_RST + 1;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        ws2812_start;
  logic [23:0] cfg_data;
  logic        cfg_start;
  logic        dout;
  logic        busy;
  logic        frame_done;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          n_cs = 0;
  int          n_fd = 0;
  int          n_words = 0;
  int          cfg_num = 0;
  logic        mode = 1'b0;
  logic [23:0] kword = '0;
  logic [23:0] sb[$];

  ws2812_ctrl #(
    .T_BIT  (T_BIT),
    .T0H    (T0H),
    .T1H    (T1H),
    .T_RST  (T_RST),
    .LED_NUM(N)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .ws2812_start(ws2812_start),
    .cfg_data    (cfg_data),
    .cfg_start   (cfg_start),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b ^ 8'h5A, ~b};
  endfunction

  // select stage model
  always @(posedge clk) begin
    if (sys_rst) cfg_num <= 0;
    else if (cfg_start) cfg_num <= (cfg_num == N - 1) ? 0 : cfg_num + 1;
  end
  assign cfg_data = mode ? pat(cfg_num) : kword;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) sb.push_back(mode ? pat(i) : kword);
  endtask

  function automatic logic sig_match(input int which, input int target);
    case (which)
      0:       return busy === 1'(target);
      1:       return cfg_start === 1'(target);
      default: return frame_done === 1'(target);
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget,
                          input string tag, output int t);
    int   n;
    logic hit;
    n   = 0;
    hit = sig_match(which, target);
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = sig_match(which, target);
    end
    t = cyc;
    chk(tag, {31'b0, hit}, 1);
  endtask

  task automatic start_pulse();
    ws2812_start = 1'b1;
    @(negedge clk);
    ws2812_start = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy !== 1'b0) seen++;
    end
    chk(tag, seen, 0);
  endtask

  // dout decoder: rebuilds words, checks each high time and bit period
  initial begin : monitor
    logic        prev;
    logic [23:0] cur;
    logic [23:0] dec;
    int          nbits, wif, t_rise, h;
    logic        gap;
    prev = 1'b0; cur = '0; dec = '0; nbits = 0; wif = 0; t_rise = 0; gap = 1'b0;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        sb.delete();
        nbits = 0; wif = 0; gap = 1'b0;
      end else begin
        if (cfg_start === 1'b1) n_cs++;
        if (frame_done === 1'b1) begin
          n_fd++;
          wif = 0;
          gap = 1'b0;
        end
        if (dout === 1'b1 && prev === 1'b0) begin
          if (nbits == 0) begin
            if (gap) chk("gap_period", cyc - t_rise, T_BIT + 2);
            chk("sb_level", {31'b0, sb.size() != 0}, 1);
            cur = (sb.size() != 0) ? sb.pop_front() : '0;
          end else begin
            chk("bit_period", cyc - t_rise, T_BIT);
          end
          t_rise = cyc;
        end else if (dout === 1'b0 && prev === 1'b1) begin
          h = cyc - t_rise;
          chk("bit_high", h, cur[23 - nbits] ? T1H : T0H);
          dec = {dec[22:0], h == T1H};
          nbits++;
          if (nbits == 24) begin
            chk("word", {8'b0, dec}, {8'b0, cur});
            n_words++;
            nbits = 0;
            wif++;
            gap = (wif < N);
          end
        end
      end
      prev = dout;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tL, tC, tI, tD, tF, tR, bcs, bfd, bw;
    sys_rst = 1'b1;
    ws2812_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {31'b0, dout}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_cfg_start", {31'b0, cfg_start}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    sys_rst = 1'b0;
    idle_check("post_rst_idle", 20);

    // constant FF0000: latency and frame length
    mode = 1'b0; kword = 24'hFF0000;
    bcs = n_cs; bfd = n_fd; bw = n_words;
    push_frame();
    start_pulse();
    wait_for(0, 1, 4, "b_load", tL);
    wait_for(1, 1, 400, "b_cfg_start", tC);
    chk("cfg_start_latency", tC - tL, 24 * T_BIT + 1);
    @(negedge clk);
    wait_for(0, 0, FRAME + 50, "b_end", tI);
    chk("frame_len", tI - tL, FRAME);
    chk("b_cs_count", n_cs - bcs, N);
    chk("b_fd_count", n_fd - bfd, 1);
    chk("b_words", n_words - bw, N);

    // indexed pattern frame and latch length
    mode = 1'b1;
    bcs = n_cs; bfd = n_fd; bw = n_words;
    push_frame();
    start_pulse();
    for (int k = 0; k < N; k++) begin
      wait_for(1, 1, 400, "c_cfg_start", tC);
      @(negedge clk);
    end
    wait_for(2, 1, T_RST + 10, "c_fd", tD);
    chk("rst_len", tD - tC, T_RST + 1);
    wait_for(0, 0, 10, "c_end", tI);
    chk("c_cs_count", n_cs - bcs, N);
    chk("c_fd_count", n_fd - bfd, 1);
    chk("c_words", n_words - bw, N);

    // all-zero and all-one words
    for (int v = 0; v < 2; v++) begin
      mode = 1'b0; kword = (v == 0) ? 24'h000000 : 24'hFFFFFF;
      bw = n_words;
      push_frame();
      start_pulse();
      wait_for(0, 0, FRAME + 50, "h_end", tI);
      chk("h_words", n_words - bw, N);
    end

    // continuous refresh: restart requested one cycle after last cfg_start
    mode = 1'b1;
    bcs = n_cs; bfd = n_fd;
    push_frame();
    start_pulse();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        wait_for(1, 1, 400, "d_cfg_start", tC);
        @(negedge clk);
      end
      if (f < 2) begin
        push_frame();
        start_pulse();
      end
      wait_for(0, 0, T_RST + 10, "d_idle", tF);
      if (f < 2) begin
        wait_for(0, 1, 4, "d_load", tR);
        chk("d_idle_gap", tR - tF, 1);
      end
    end
    idle_check("d_stop", 50);
    chk("d_fd_count", n_fd - bfd, 3);
    chk("d_cs_count", n_cs - bcs, 3 * N);

    // request during SEND and again in the last RST cycle collapse to one frame
    bcs = n_cs; bfd = n_fd;
    push_frame();
    start_pulse();
    repeat (100) @(negedge clk);
    push_frame();
    start_pulse();
    wait_for(2, 1, FRAME + 50, "e_fd", tD);
    start_pulse();
    wait_for(0, 0, 4, "e_idle", tF);
    wait_for(0, 1, 4, "e_load", tR);
    chk("e_idle_gap", tR - tF, 1);
    wait_for(0, 0, FRAME + 50, "e_end", tI);
    idle_check("e_stop", 100);
    chk("e_fd_count", n_fd - bfd, 2);
    chk("e_cs_count", n_cs - bcs, 2 * N);

    // request only in the last RST cycle
    bcs = n_cs; bfd = n_fd;
    push_frame();
    start_pulse();
    wait_for(2, 1, FRAME + 50, "f_fd", tD);
    push_frame();
    start_pulse();
    wait_for(0, 0, 4, "f_idle", tF);
    wait_for(0, 1, 4, "f_load", tR);
    chk("f_idle_gap", tR - tF, 1);
    wait_for(0, 0, FRAME + 50, "f_end", tI);
    idle_check("f_stop", 100);
    chk("f_fd_count", n_fd - bfd, 2);
    chk("f_cs_count", n_cs - bcs, 2 * N);

    // reset at LED 10, bit 5
    bcs = n_cs;
    push_frame();
    start_pulse();
    for (int k = 0; k < 10; k++) begin
      wait_for(1, 1, 400, "g_cfg_start", tC);
      @(negedge clk);
    end
    repeat (2 + 5 * T_BIT + 2) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    chk("g_dout", {31'b0, dout}, 0);
    chk("g_busy", {31'b0, busy}, 0);
    chk("g_cfg_start", {31'b0, cfg_start}, 0);
    @(negedge clk);
    sys_rst = 1'b0;
    idle_check("g_stay_idle", 400);
    chk("g_cs_stop", n_cs - bcs, 10);
    bcs = n_cs; bfd = n_fd; bw = n_words;
    push_frame();
    start_pulse();
    wait_for(0, 1, 4, "g_load", tL);
    wait_for(0, 0, FRAME + 50, "g_end", tI);
    chk("g_frame_len", tI - tL, FRAME);
    chk("g_cs_count", n_cs - bcs, N);
    chk("g_fd_count", n_fd - bfd, 1);
    chk("g_words", n_words - bw, N);

    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
